// File: rtl/sd_card_pkg.sv
// sd_card_pkg: shared constants and state encoding for the SPI-mode SD card emulator.
//   Holds command indices, R1 response codes, the data start token, CRC constants
//   and the byte-level state machine encoding.
package sd_card_pkg;

   localparam int unsigned ADDR_W  = 24;
   localparam int unsigned BLK_W   = 15;   // arg[23:9]: block part of the byte address
   localparam int unsigned CNT_W   = 10;
   localparam int unsigned BUSY_W  = 8;

   localparam logic [5:0] CMD0  = 6'd0;
   localparam logic [5:0] CMD1  = 6'd1;
   localparam logic [5:0] CMD17 = 6'd17;

   localparam logic [7:0] R1_READY    = 8'h00;
   localparam logic [7:0] R1_IDLE     = 8'h01;
   localparam logic [7:0] R1_ILLEGAL  = 8'h04;
   localparam logic [7:0] R1_ILL_IDLE = 8'h05;
   localparam logic [7:0] TOKEN_START = 8'hFE;
   localparam logic [7:0] FILL_BYTE   = 8'hFF;

   localparam logic [15:0] CRC_POLY = 16'h1021;
   localparam logic [15:0] CRC_INIT = 16'h0000;

   typedef enum logic [2:0] {
      ST_IDLE, ST_CMD, ST_NCR, ST_R1, ST_DWAIT, ST_TOKEN, ST_DATA, ST_CRC
   } state_t;

endpackage

// File: rtl/sd_crc16.sv
// sd_crc16: byte-serial CRC16-CCITT (poly 0x1021, init 0x0000), MSB first.
//   i_clear : restart the checksum
//   i_en    : fold i_data into the checksum this clk
//   o_crc   : running checksum
module sd_crc16
   import sd_card_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        i_clear,
   input  logic        i_en,
   input  logic [7:0]  i_data,
   output logic [15:0] o_crc
);

   logic [15:0] r_crc;

   function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] d);
      logic [15:0] r;
      r = c ^ {d, 8'h00};
      for (int i = 0; i < 8; i++)
         r = r[15] ? ({r[14:0], 1'b0} ^ CRC_POLY) : {r[14:0], 1'b0};
      return r;
   endfunction

   always_ff @(posedge clk or posedge reset) begin
      if (reset)        r_crc <= CRC_INIT;
      else if (i_clear) r_crc <= CRC_INIT;
      else if (i_en)    r_crc <= crc_byte(r_crc, i_data);
   end

   assign o_crc = r_crc;

endmodule

// File: rtl/sd_card_emu.sv
// sd_card_emu: SPI-mode SD card emulator answering CMD0, CMD1 and CMD17 single-block
// reads from an external byte-wide backing store.
//   clk, reset            : system clock, asynchronous active-high reset
//   spi_cs/clk/di, spi_do : host SPI bus (mode 0), sampled through 2-FF synchronizers
//   mem_address/read/data : backing store, data valid 1 clk after the read strobe
//   initialized           : set once CMD1 has answered 0x00
//   read_count            : CMD17 data blocks started (wraps)
// Build option SD_CARD_EMU_CRC_EN: real CRC16 on data blocks, otherwise 0xFFFF is sent.
module sd_card_emu
   import sd_card_pkg::*;
#(
   parameter int unsigned INIT_BUSY_COUNT = 2,
   parameter int unsigned DATA_DELAY      = 1
)(
   input  logic              clk,
   input  logic              reset,
   input  logic              spi_cs,
   input  logic              spi_clk,
   input  logic              spi_di,
   output logic              spi_do,
   output logic [ADDR_W-1:0] mem_address,
   output logic              mem_read,
   input  logic [7:0]        mem_data,
   output logic              initialized,
   output logic [7:0]        read_count
);

   logic [1:0]        r_cs_sync, r_clk_sync, r_di_sync;
   logic              r_clk_q;
   logic [2:0]        r_bit_cnt;
   logic [6:0]        r_rx;
   logic [7:0]        r_tx, r_tx_nxt, r_r1, r_read_cnt;
   state_t            r_state;
   logic [CNT_W-1:0]  r_cnt;
   logic [5:0]        r_cmd;
   logic [BLK_W-1:0]  r_blk;
   logic [BUSY_W-1:0] r_busy;
   logic              r_init, r_mem_read, r_rd_d;
   logic [ADDR_W-1:0] r_mem_addr;

   logic       w_cs, w_sclk, w_di, w_rise, w_fall, w_byte_done;
   logic [7:0] w_byte;
   logic [15:0] w_crc;

   // Input synchronizers; idle values keep the card deselected out of reset
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cs_sync  <= 2'b11;
         r_clk_sync <= 2'b00;
         r_di_sync  <= 2'b11;
         r_clk_q    <= 1'b0;
      end else begin
         r_cs_sync  <= {r_cs_sync[0], spi_cs};
         r_clk_sync <= {r_clk_sync[0], spi_clk};
         r_di_sync  <= {r_di_sync[0], spi_di};
         r_clk_q    <= r_clk_sync[1];
      end
   end

   assign w_cs        = r_cs_sync[1];
   assign w_sclk      = r_clk_sync[1];
   assign w_di        = r_di_sync[1];
   assign w_rise      = w_sclk & ~r_clk_q;
   assign w_fall      = ~w_sclk & r_clk_q;
   assign w_byte      = {r_rx, w_di};
   assign w_byte_done = w_rise & (r_bit_cnt == 3'd7);

`ifdef SD_CARD_EMU_CRC_EN
   // Checksum restarts while the token goes out and folds in each fetched data byte
   sd_crc16 u_crc (
      .clk     (clk),
      .reset   (reset),
      .i_clear (r_state == ST_TOKEN),
      .i_en    (r_rd_d),
      .i_data  (mem_data),
      .o_crc   (w_crc)
   );
`else
   assign w_crc = 16'hFFFF;
`endif

   // Byte-level protocol FSM; r_state names the byte currently on the wire and
   // r_tx_nxt is the byte loaded on the falling edge that follows its 8th rising edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= ST_IDLE;
         r_bit_cnt  <= 3'd0;
         r_rx       <= 7'd0;
         r_tx       <= FILL_BYTE;
         r_tx_nxt   <= FILL_BYTE;
         r_r1       <= FILL_BYTE;
         r_cnt      <= '0;
         r_cmd      <= 6'd0;
         r_blk      <= '0;
         r_busy     <= '0;
         r_init     <= 1'b0;
         r_read_cnt <= 8'd0;
         r_mem_read <= 1'b0;
         r_rd_d     <= 1'b0;
         r_mem_addr <= '0;
      end else begin
         r_mem_read <= 1'b0;
         r_rd_d     <= r_mem_read;
         if (w_cs) begin
            r_state   <= ST_IDLE;
            r_bit_cnt <= 3'd0;
            r_tx      <= FILL_BYTE;
            r_tx_nxt  <= FILL_BYTE;
            r_cnt     <= '0;
         end else begin
            if (r_rd_d) r_tx_nxt <= mem_data;
            if (w_fall) begin
               if (r_bit_cnt == 3'd0) r_tx <= r_tx_nxt;
               else                   r_tx <= {r_tx[6:0], 1'b1};
            end
            if (w_rise) begin
               r_rx      <= w_byte[6:0];
               r_bit_cnt <= r_bit_cnt + 3'd1;
            end
            if (w_byte_done) begin
               case (r_state)
                  ST_IDLE: if (w_byte[7:6] == 2'b01) begin
                     r_state <= ST_CMD;
                     r_cmd   <= w_byte[5:0];
                     r_cnt   <= CNT_W'(1);
                  end
                  ST_CMD: begin
                     if (r_cnt == CNT_W'(2)) r_blk[14:7] <= w_byte;
                     if (r_cnt == CNT_W'(3)) r_blk[6:0]  <= w_byte[7:1];
                     if (r_cnt == CNT_W'(5)) begin
                        r_state <= ST_NCR;
                        r_cnt   <= '0;
                        // Response and its side effects are decided once the frame is complete
                        case (r_cmd)
                           CMD0: begin
                              r_r1   <= R1_IDLE;
                              r_init <= 1'b0;
                              r_busy <= '0;
                           end
                           CMD1: if (r_busy < BUSY_W'(INIT_BUSY_COUNT)) begin
                              r_r1   <= R1_IDLE;
                              r_busy <= r_busy + BUSY_W'(1);
                           end else begin
                              r_r1   <= R1_READY;
                              r_init <= 1'b1;
                           end
                           CMD17:   r_r1 <= r_init ? R1_READY : R1_ILL_IDLE;
                           default: r_r1 <= R1_ILLEGAL | {7'd0, ~r_init};
                        endcase
                     end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                     end
                  end
                  ST_NCR: begin
                     r_state  <= ST_R1;
                     r_tx_nxt <= r_r1;
                  end
                  ST_R1: if (r_cmd == CMD17 && r_r1 == R1_READY) begin
                     r_cnt <= '0;
                     if (DATA_DELAY == 0) begin
                        r_state    <= ST_TOKEN;
                        r_tx_nxt   <= TOKEN_START;
                        r_read_cnt <= r_read_cnt + 8'd1;
                     end else begin
                        r_state  <= ST_DWAIT;
                        r_tx_nxt <= FILL_BYTE;
                     end
                  end else begin
                     r_state  <= ST_IDLE;
                     r_tx_nxt <= FILL_BYTE;
                  end
                  ST_DWAIT: if (r_cnt == CNT_W'(DATA_DELAY - 1)) begin
                     r_state    <= ST_TOKEN;
                     r_tx_nxt   <= TOKEN_START;
                     r_read_cnt <= r_read_cnt + 8'd1;
                  end else begin
                     r_cnt    <= r_cnt + CNT_W'(1);
                     r_tx_nxt <= FILL_BYTE;
                  end
                  ST_TOKEN: begin
                     r_state    <= ST_DATA;
                     r_cnt      <= '0;
                     r_mem_read <= 1'b1;
                     r_mem_addr <= {r_blk, 9'd0};
                  end
                  ST_DATA: if (r_cnt == CNT_W'(511)) begin
                     r_state  <= ST_CRC;
                     r_cnt    <= '0;
                     r_tx_nxt <= w_crc[15:8];
                  end else begin
                     r_cnt      <= r_cnt + CNT_W'(1);
                     r_mem_read <= 1'b1;
                     r_mem_addr <= {r_blk, 9'(r_cnt + CNT_W'(1))};
                  end
                  ST_CRC: if (r_cnt == '0) begin
                     r_cnt    <= CNT_W'(1);
                     r_tx_nxt <= w_crc[7:0];
                  end else begin
                     r_state  <= ST_IDLE;
                     r_tx_nxt <= FILL_BYTE;
                  end
                  default: r_state <= ST_IDLE;
               endcase
            end
         end
      end
   end

   assign spi_do      = r_tx[7];
   assign mem_address = r_mem_addr;
   assign mem_read    = r_mem_read;
   assign initialized = r_init;
   assign read_count  = r_read_cnt;

endmodule

// File: tb/tb_sd_card_emu.sv
// tb_sd_card_emu: scoreboard bench for sd_card_emu. Expected card bytes are queued
// as each SPI transaction is built and popped as the host clocks them in.
// Honours SD_CARD_EMU_CRC_EN for the expected CRC bytes.
module tb_sd_card_emu;

   localparam int HALF = 4;   // spi_clk half period in clk cycles

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        spi_cs = 1'b1, spi_clk = 1'b0, spi_di = 1'b1;
   logic        spi_do, mem_read, initialized;
   logic [23:0] mem_address;
   logic [7:0]  mem_data = 8'h00;
   logic [7:0]  read_count;

   int          n_vec = 0, n_err = 0;
   logic [7:0]  exp_q[$];
   bit          mem_zero = 1'b0;
   int          rd_cnt = 0;
   logic [23:0] last_addr = 24'h0;

   always #5 clk = ~clk;

   sd_card_emu dut (
      .clk         (clk),
      .reset       (reset),
      .spi_cs      (spi_cs),
      .spi_clk     (spi_clk),
      .spi_di      (spi_di),
      .spi_do      (spi_do),
      .mem_address (mem_address),
      .mem_read    (mem_read),
      .mem_data    (mem_data),
      .initialized (initialized),
      .read_count  (read_count)
   );

   // Backing store: store[x] = x[7:0], or all zero; data appears 1 clk after the strobe
   always @(posedge clk) begin
      if (mem_read) begin
         mem_data  <= mem_zero ? 8'h00 : mem_address[7:0];
         rd_cnt    = rd_cnt + 1;
         last_addr = mem_address;
      end
   end

   function automatic logic [15:0] crc_upd(input logic [15:0] c, input logic [7:0] d);
      logic [15:0] r;
      logic        fb;
      r = c;
      for (int i = 7; i >= 0; i--) begin
         fb = r[15] ^ d[i];
         r  = {r[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
      end
      return r;
   endfunction

   task automatic clks(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
      for (int i = 7; i >= 0; i--) begin
         spi_di  = tx[i];
         clks(HALF);
         rx[i]   = spi_do;
         spi_clk = 1'b1;
         clks(HALF);
         spi_clk = 1'b0;
      end
   endtask

   task automatic cs_low();
      spi_cs = 1'b0;
      clks(6);
   endtask

   task automatic cs_high();
      spi_cs = 1'b1;
      spi_di = 1'b1;
      clks(6);
   endtask

   task automatic test_reset();
      reset = 1'b1; spi_cs = 1'b1; spi_clk = 1'b0; spi_di = 1'b1;
      clks(3);
      n_vec++; if (spi_do !== 1'b1) begin n_err++; $display("FAIL reset spi_do: got %b want 1", spi_do); end
      n_vec++; if (mem_read !== 1'b0) begin n_err++; $display("FAIL reset mem_read: got %b want 0", mem_read); end
      n_vec++; if (mem_address !== 24'h0) begin n_err++; $display("FAIL reset mem_address: got %h want 0", mem_address); end
      n_vec++; if (initialized !== 1'b0) begin n_err++; $display("FAIL reset initialized: got %b want 0", initialized); end
      n_vec++; if (read_count !== 8'h00) begin n_err++; $display("FAIL reset read_count: got %h want 0", read_count); end
      reset = 1'b0;
      clks(3);
   endtask

   task automatic test_cs_high();
      logic [7:0] rx, e;
      int rd0;
      rd0 = rd_cnt;
      for (int k = 0; k < 10; k++) begin
         exp_q.push_back(8'hFF);
         spi_byte(8'hFF, rx);
         e = exp_q.pop_front();
         n_vec++; if (rx !== e) begin n_err++; $display("FAIL cs_high byte %0d: got %h want %h", k, rx, e); end
      end
      n_vec++; if (rd_cnt !== rd0) begin n_err++; $display("FAIL cs_high mem_read count: got %0d want %0d", rd_cnt, rd0); end
   endtask

   task automatic test_cmd0();
      logic [7:0] tx[8];
      logic [7:0] rx, e;
      tx = '{8'h40, 8'h00, 8'h00, 8'h00, 8'h00, 8'h95, 8'hFF, 8'hFF};
      for (int k = 0; k < 7; k++) exp_q.push_back(8'hFF);
      exp_q.push_back(8'h01);
      cs_low();
      for (int k = 0; k < 8; k++) begin
         spi_byte(tx[k], rx);
         e = exp_q.pop_front();
         n_vec++; if (rx !== e) begin n_err++; $display("FAIL cmd0 byte %0d: got %h want %h", k, rx, e); end
      end
      cs_high();
      n_vec++; if (initialized !== 1'b0) begin n_err++; $display("FAIL cmd0 initialized: got %b want 0", initialized); end
   endtask

   task automatic test_cmd17_uninit();
      logic [7:0] tx[12];
      logic [7:0] rx, e;
      int rd0;
      tx = '{8'h51, 8'h00, 8'h01, 8'h22, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
      for (int k = 0; k < 12; k++) exp_q.push_back(k == 7 ? 8'h05 : 8'hFF);
      rd0 = rd_cnt;
      cs_low();
      for (int k = 0; k < 12; k++) begin
         spi_byte(tx[k], rx);
         e = exp_q.pop_front();
         n_vec++; if (rx !== e) begin n_err++; $display("FAIL cmd17_uninit byte %0d: got %h want %h", k, rx, e); end
      end
      cs_high();
      n_vec++; if (rd_cnt !== rd0) begin n_err++; $display("FAIL cmd17_uninit mem_read count: got %0d want %0d", rd_cnt, rd0); end
      n_vec++; if (read_count !== 8'h00) begin n_err++; $display("FAIL cmd17_uninit read_count: got %h want 0", read_count); end
   endtask

   task automatic test_cmd1();
      logic [7:0] tx[8];
      logic [7:0] rx, e;
      tx = '{8'h41, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 8'hFF};
      for (int n = 0; n < 3; n++) begin
         for (int k = 0; k < 7; k++) exp_q.push_back(8'hFF);
         exp_q.push_back(n < 2 ? 8'h01 : 8'h00);
         cs_low();
         for (int k = 0; k < 8; k++) begin
            spi_byte(tx[k], rx);
            e = exp_q.pop_front();
            n_vec++; if (rx !== e) begin n_err++; $display("FAIL cmd1 #%0d byte %0d: got %h want %h", n, k, rx, e); end
         end
         cs_high();
         n_vec++;
         if (initialized !== (n == 2)) begin
            n_err++; $display("FAIL cmd1 #%0d initialized: got %b want %b", n, initialized, (n == 2));
         end
      end
   endtask

   // CMD17 at arg 0x00012200; transfers n_data data bytes (full block when 512)
   task automatic test_block(input bit zero, input int n_data, input logic [7:0] exp_rc);
      logic [7:0]  txq[$];
      logic [7:0]  cmd[6];
      logic [7:0]  rx, e, d;
      logic [15:0] crc;
      int rd0, idx;
      cmd = '{8'h51, 8'h00, 8'h01, 8'h22, 8'h00, 8'hFF};
      mem_zero = zero;
      rd0 = rd_cnt;
      crc = 16'h0000;
      for (int k = 0; k < 6; k++) begin txq.push_back(cmd[k]); exp_q.push_back(8'hFF); end
      for (int k = 0; k < 4; k++) txq.push_back(8'hFF);
      exp_q.push_back(8'hFF); exp_q.push_back(8'h00); exp_q.push_back(8'hFF); exp_q.push_back(8'hFE);
      for (int k = 0; k < n_data; k++) begin
         d   = zero ? 8'h00 : 8'(k);
         crc = crc_upd(crc, d);
         txq.push_back(8'hFF);
         exp_q.push_back(d);
      end
      if (n_data == 512) begin
`ifdef SD_CARD_EMU_CRC_EN
         exp_q.push_back(crc[15:8]); exp_q.push_back(crc[7:0]);
`else
         exp_q.push_back(8'hFF); exp_q.push_back(8'hFF);
`endif
         exp_q.push_back(8'hFF);
         for (int k = 0; k < 3; k++) txq.push_back(8'hFF);
      end
      cs_low();
      idx = 0;
      while (txq.size() > 0) begin
         spi_byte(txq.pop_front(), rx);
         e = exp_q.pop_front();
         n_vec++; if (rx !== e) begin n_err++; $display("FAIL block byte %0d: got %h want %h", idx, rx, e); end
         idx++;
      end
      n_vec++; if (read_count !== exp_rc) begin n_err++; $display("FAIL block read_count: got %0d want %0d", read_count, exp_rc); end
      if (n_data == 512) begin
         cs_high();
         n_vec++; if (rd_cnt - rd0 !== 512) begin n_err++; $display("FAIL block mem_read count: got %0d want 512", rd_cnt - rd0); end
         n_vec++; if (last_addr !== 24'h0123FF) begin n_err++; $display("FAIL block last address: got %h want 0123ff", last_addr); end
      end
   endtask

   task automatic test_abort();
      int rd0;
      test_block(1'b0, 101, 8'd2);
      spi_cs = 1'b1;
      spi_di = 1'b1;
      clks(3);
      n_vec++; if (spi_do !== 1'b1) begin n_err++; $display("FAIL abort spi_do: got %b want 1", spi_do); end
      rd0 = rd_cnt;
      clks(40);
      n_vec++; if (rd_cnt !== rd0) begin n_err++; $display("FAIL abort mem_read after cs: got %0d want %0d", rd_cnt, rd0); end
      n_vec++; if (initialized !== 1'b1) begin n_err++; $display("FAIL abort initialized: got %b want 1", initialized); end
      n_vec++; if (read_count !== 8'd2) begin n_err++; $display("FAIL abort read_count: got %0d want 2", read_count); end
   endtask

   task automatic test_reset_mid();
      test_block(1'b0, 5, 8'd4);
      #2 reset = 1'b1;
      #1;
      n_vec++; if (spi_do !== 1'b1) begin n_err++; $display("FAIL reset_mid spi_do: got %b want 1", spi_do); end
      n_vec++; if (mem_read !== 1'b0) begin n_err++; $display("FAIL reset_mid mem_read: got %b want 0", mem_read); end
      n_vec++; if (initialized !== 1'b0) begin n_err++; $display("FAIL reset_mid initialized: got %b want 0", initialized); end
      n_vec++; if (read_count !== 8'd0) begin n_err++; $display("FAIL reset_mid read_count: got %0d want 0", read_count); end
      spi_cs = 1'b1; spi_clk = 1'b0; spi_di = 1'b1;
      clks(2);
      reset = 1'b0;
      clks(6);
   endtask

   initial begin
      test_reset();
      test_cs_high();
      test_cmd0();
      test_cmd17_uninit();
      test_cmd1();
      test_block(1'b0, 512, 8'd1);
      test_abort();
      test_block(1'b1, 512, 8'd3);
      test_reset_mid();
      test_cmd17_uninit();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
